// File: rtl/aoc_pkg.sv
// rtl/aoc_pkg.sv - shared ASCII constants, parser state and range record types
package aoc_pkg;

   localparam int DATA_WIDTH = 34;
   localparam int DIGS_WIDTH = 8;

   localparam logic [7:0] ASCII_0     = 8'h30;
   localparam logic [7:0] ASCII_9     = 8'h39;
   localparam logic [7:0] ASCII_DASH  = 8'h2D;
   localparam logic [7:0] ASCII_COMMA = 8'h2C;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_CR    = 8'h0D;

   typedef enum logic [2:0] {
      S_LO   = 3'd0,
      S_HI   = 3'd1,
      S_EMIT = 3'd2,
      S_SKIP = 3'd3,
      S_DONE = 3'd4
   } parser_state_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] lo_m1;
      logic [DATA_WIDTH-1:0] lo_digs;
      logic [DATA_WIDTH-1:0] hi;
      logic [DATA_WIDTH-1:0] hi_digs;
   } range_t;

   function automatic logic is_digit(input logic [7:0] c);
      return (c >= ASCII_0) && (c <= ASCII_9);
   endfunction

endpackage

// File: rtl/range_stream_parser_if.sv
// rtl/range_stream_parser_if.sv - byte-in / range-out handshake bundle of range_stream_parser
interface range_stream_parser_if;
   import aoc_pkg::*;

   logic                  in_valid;
   logic                  in_ready;
   logic [7:0]            in_data;
   logic                  in_last;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_lo_m1;
   logic [DATA_WIDTH-1:0] out_lo_digs;
   logic [DATA_WIDTH-1:0] out_hi;
   logic [DATA_WIDTH-1:0] out_hi_digs;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_lo_m1, out_lo_digs, out_hi, out_hi_digs
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_lo_m1, out_lo_digs, out_hi, out_hi_digs
   );

endinterface

// File: rtl/dec_field_acc.sv
// rtl/dec_field_acc.sv - decimal field accumulator with digit count, power-of-ten flag and overflow detect
// Outputs show the field including the digit presented this cycle, so a digit that also ends the field is seen.
module dec_field_acc
   import aoc_pkg::*;
#(
   parameter int MAX_DIGITS = 10
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  digit_en,
   input  logic [3:0]            digit,
   output logic [DATA_WIDTH-1:0] value,
   output logic [DIGS_WIDTH-1:0] digs,
   output logic                  is_pow10,
   output logic                  ovf
);

   logic [DATA_WIDTH-1:0] acc_q;
   logic [DIGS_WIDTH-1:0] digs_q;
   logic                  pow10_q;
   logic                  take;

   assign ovf  = digit_en && (digs_q >= DIGS_WIDTH'(MAX_DIGITS));
   assign take = digit_en && !ovf;

   always_comb begin
      value    = acc_q;
      digs     = digs_q;
      is_pow10 = pow10_q;
      if (take) begin
         value    = (acc_q << 3) + (acc_q << 1) + DATA_WIDTH'(digit);
         digs     = digs_q + 1'b1;
         is_pow10 = (digs_q == '0) ? (digit == 4'd1) : (pow10_q && (digit == 4'd0));
      end
   end

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         acc_q   <= '0;
         digs_q  <= '0;
         pow10_q <= 1'b0;
      end else if (take) begin
         acc_q   <= value;
         digs_q  <= digs;
         pow10_q <= is_pow10;
      end
   end

endmodule

// File: rtl/range_stream_parser.sv
// rtl/range_stream_parser.sv - parses "lo-hi,..." ASCII into (lo-1, digits) / (hi, digits) ranges
// Optional RANGE_PARSER_STATS_EN adds a saturating range_cnt and an err_evt pulse.
module range_stream_parser
   import aoc_pkg::*;
#(
   parameter int MAX_DIGITS = 10
) (
   input  logic                 clock,
   input  logic                 reset,
   range_stream_parser_if.slave bus,
   output logic                 fmt_err,
   output logic [31:0]          range_cnt
);

   parser_state_t         state, state_nxt, err_dest;
   logic                  accept, b_digit, b_dash, b_sep, b_cr, b_term;
   logic                  acc_clear, digit_en, err, latch_lo, latch_hi, hi_ok;
   logic [DATA_WIDTH-1:0] f_value;
   logic [DIGS_WIDTH-1:0] f_digs;
   logic                  f_is_pow10, f_ovf;
   logic [DATA_WIDTH-1:0] lo_q;
   logic [DIGS_WIDTH-1:0] lo_digs_q, lo_m1_digs;
   logic                  lo_pow10_q;
   range_t                out_q;
   logic                  out_valid_q, emit_last_q;

   assign bus.in_ready = (state != S_EMIT);
   assign accept  = bus.in_valid && bus.in_ready;
   assign b_digit = is_digit(bus.in_data);
   assign b_dash  = (bus.in_data == ASCII_DASH);
   assign b_sep   = (bus.in_data == ASCII_COMMA) || (bus.in_data == ASCII_LF);
   assign b_cr    = (bus.in_data == ASCII_CR);
   assign b_term  = b_sep || bus.in_last;
   assign hi_ok   = (f_digs != '0) && (lo_q <= f_value);
   assign err_dest = bus.in_last ? S_DONE : (b_sep ? S_LO : S_SKIP);

   // lo of the form 10..0 loses one digit when decremented; lo==1 keeps its single digit
   assign lo_m1_digs = (lo_pow10_q && (lo_digs_q > 8'd1)) ? lo_digs_q - 8'd1 : lo_digs_q;

   dec_field_acc #(.MAX_DIGITS(MAX_DIGITS)) u_field (
      .clock    (clock),
      .reset    (reset),
      .clear    (acc_clear),
      .digit_en (digit_en),
      .digit    (bus.in_data[3:0]),
      .value    (f_value),
      .digs     (f_digs),
      .is_pow10 (f_is_pow10),
      .ovf      (f_ovf)
   );

   always_comb begin
      state_nxt = state;
      acc_clear = 1'b0;
      digit_en  = 1'b0;
      err       = 1'b0;
      latch_lo  = 1'b0;
      latch_hi  = 1'b0;
      case (state)
         S_LO: if (accept) begin
            if (b_digit) begin
               digit_en = 1'b1;
               if (f_ovf || bus.in_last) err = 1'b1;
            end else if (b_dash) begin
               if ((f_digs == '0) || (f_value == '0) || bus.in_last) err = 1'b1;
               else begin
                  latch_lo  = 1'b1;
                  acc_clear = 1'b1;
                  state_nxt = S_HI;
               end
            end else if (b_term) begin
               if (f_digs != '0) err = 1'b1;
               else if (bus.in_last) state_nxt = S_DONE;
            end else if (!b_cr) begin
               err = 1'b1;
            end
         end
         S_HI: if (accept) begin
            if (b_digit) begin
               digit_en = 1'b1;
               if (f_ovf) err = 1'b1;
               else if (bus.in_last) begin
                  if (hi_ok) begin
                     latch_hi  = 1'b1;
                     acc_clear = 1'b1;
                     state_nxt = S_EMIT;
                  end else err = 1'b1;
               end
            end else if (b_term) begin
               if (hi_ok) begin
                  latch_hi  = 1'b1;
                  acc_clear = 1'b1;
                  state_nxt = S_EMIT;
               end else err = 1'b1;
            end else if (!b_cr) begin
               err = 1'b1;
            end
         end
         S_EMIT: if (bus.out_ready) state_nxt = emit_last_q ? S_DONE : S_LO;
         S_SKIP: if (accept && b_term) state_nxt = bus.in_last ? S_DONE : S_LO;
         S_DONE: state_nxt = S_DONE;
         default: state_nxt = S_LO;
      endcase
      if (err) begin
         state_nxt = err_dest;
         acc_clear = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= S_LO;
         lo_q        <= '0;
         lo_digs_q   <= '0;
         lo_pow10_q  <= 1'b0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         emit_last_q <= 1'b0;
         fmt_err     <= 1'b0;
      end else begin
         state <= state_nxt;
         if (latch_lo) begin
            lo_q       <= f_value;
            lo_digs_q  <= f_digs;
            lo_pow10_q <= f_is_pow10;
         end
         if (latch_hi) begin
            out_q.lo_m1   <= lo_q - 1'b1;
            out_q.lo_digs <= DATA_WIDTH'(lo_m1_digs);
            out_q.hi      <= f_value;
            out_q.hi_digs <= DATA_WIDTH'(f_digs);
            out_valid_q   <= 1'b1;
            emit_last_q   <= bus.in_last;
         end else if ((state == S_EMIT) && bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
         if (err) fmt_err <= 1'b1;
      end
   end

   assign bus.out_valid   = out_valid_q;
   assign bus.out_lo_m1   = out_q.lo_m1;
   assign bus.out_lo_digs = out_q.lo_digs;
   assign bus.out_hi      = out_q.hi;
   assign bus.out_hi_digs = out_q.hi_digs;

`ifdef RANGE_PARSER_STATS_EN
   logic [31:0] cnt_q;
   logic        err_evt;

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q   <= '0;
         err_evt <= 1'b0;
      end else begin
         err_evt <= err;
         if (out_valid_q && bus.out_ready && (cnt_q != '1)) cnt_q <= cnt_q + 32'd1;
      end
   end

   assign range_cnt = cnt_q;
`else
   assign range_cnt = '0;
`endif

endmodule

// File: tb/tb_range_stream_parser.sv
// tb/tb_range_stream_parser.sv - self-checking bench for range_stream_parser (RANGE_PARSER_STATS_EN aware)
module tb_range_stream_parser;
   import aoc_pkg::*;

   localparam int W = DATA_WIDTH;
   typedef struct packed {
      logic [W-1:0] lo_m1;
      logic [W-1:0] lo_digs;
      logic [W-1:0] hi;
      logic [W-1:0] hi_digs;
   } rng_t;

`ifdef RANGE_PARSER_STATS_EN
   localparam logic [31:0] EXP_CNT1 = 32'd1;
`else
   localparam logic [31:0] EXP_CNT1 = 32'd0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        fmt_err;
   logic [31:0] range_cnt;

   range_stream_parser_if bus ();

   range_stream_parser #(.MAX_DIGITS(10)) dut (
      .clock     (clock),
      .reset     (reset),
      .bus       (bus.slave),
      .fmt_err   (fmt_err),
      .range_cnt (range_cnt)
   );

   initial forever #5 clock = ~clock;

   int   total = 0, passed = 0, timeouts = 0, stable_viol = 0;
   int   rdy_mode = 0;
   bit   gap_en = 1'b0;
   bit   exp_err = 1'b0;
   rng_t exp_q[$];
   rng_t got_q[$];
   logic [8:0] stream[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Decimal digit count of a value; zero counts as one digit
   function automatic longint unsigned ndig(input longint unsigned v);
      longint unsigned n = 1;
      while (v >= 10) begin
         v = v / 10;
         n++;
      end
      return n;
   endfunction

   function automatic longint unsigned gen_num(input int nd);
      longint unsigned v = longint'($urandom_range(1, 9));
      for (int i = 1; i < nd; i++) v = v * 10 + longint'($urandom_range(0, 9));
      return v;
   endfunction

   function automatic longint unsigned pick();
      int nd = $urandom_range(1, 10);
      longint unsigned p = 1;
      if ($urandom_range(0, 3) == 0) begin
         for (int i = 1; i < nd; i++) p = p * 10;
         return p;
      end
      return gen_num(nd);
   endfunction

   task automatic push_exp(input longint unsigned a, input longint unsigned b,
                           input longint unsigned c, input longint unsigned d);
      rng_t r;
      r.lo_m1 = W'(a); r.lo_digs = W'(b); r.hi = W'(c); r.hi_digs = W'(d);
      exp_q.push_back(r);
   endtask

   task automatic expect_range(input longint unsigned lo, input longint unsigned hi);
      push_exp(lo - 1, ndig(lo - 1), hi, ndig(hi));
   endtask

   task automatic push_str(input string s, input bit last_on_end);
      for (int i = 0; i < s.len(); i++)
         stream.push_back({last_on_end && (i == s.len() - 1), s[i]});
   endtask

   task automatic gen_token(input bit final_tok);
      int kind = final_tok ? 0 : $urandom_range(0, 7);
      longint unsigned a = pick(), b = pick(), lo, hi;
      string s;
      int cr_pos;
      lo = (a < b) ? a : b;
      hi = (a < b) ? b : a;
      case (kind)
         4: begin
            s = $sformatf("%0d-%0d", hi, lo);
            if (a == b) expect_range(lo, hi); else exp_err = 1'b1;
         end
         5: begin s = $sformatf("0-%0d", hi); exp_err = 1'b1; end
         6: begin s = $sformatf("%0dx-%0d", lo, hi); exp_err = 1'b1; end
         7: begin s = $sformatf("%0d7-%0d", gen_num(10), hi); exp_err = 1'b1; end
         default: begin s = $sformatf("%0d-%0d", lo, hi); expect_range(lo, hi); end
      endcase
      cr_pos = ($urandom_range(0, 3) == 0) ? $urandom_range(0, s.len() - 1) : -1;
      for (int i = 0; i < s.len(); i++) begin
         if (i == cr_pos) stream.push_back({1'b0, ASCII_CR});
         stream.push_back({final_tok && (i == s.len() - 1), s[i]});
      end
      if (!final_tok) begin
         case ($urandom_range(0, 3))
            0: push_str(",", 1'b0);
            1: push_str("\n", 1'b0);
            2: push_str(",\n", 1'b0);
            default: push_str("\r\n", 1'b0);
         endcase
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last);
      int waited = 0;
      @(negedge clock);
      if (gap_en && ($urandom_range(0, 3) == 0)) begin
         bus.in_valid = 1'b0;
         repeat ($urandom_range(1, 2)) @(negedge clock);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      bus.in_last  = last;
      while (bus.in_ready !== 1'b1 && waited < 100) begin
         @(negedge clock);
         waited++;
      end
      if (waited >= 100) timeouts++;
   endtask

   task automatic send_stream();
      logic [8:0] v;
      while (stream.size() > 0) begin
         v = stream.pop_front();
         send_byte(v[7:0], v[8]);
      end
   endtask

   task automatic drain(input string tag);
      int quiet = 0, n = 0;
      @(negedge clock);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      while (quiet < 4 && n < 1000) begin
         @(negedge clock);
         n++;
         if (bus.out_valid === 1'b1) quiet = 0; else quiet++;
      end
      check({tag, "_drain_timeout"}, 64'(n >= 1000), 64'd0);
   endtask

   task automatic compare_ranges(input string tag);
      check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         check($sformatf("%s[%0d].lo_m1", tag, i),   got_q[i].lo_m1,   exp_q[i].lo_m1);
         check($sformatf("%s[%0d].lo_digs", tag, i), got_q[i].lo_digs, exp_q[i].lo_digs);
         check($sformatf("%s[%0d].hi", tag, i),      got_q[i].hi,      exp_q[i].hi);
         check($sformatf("%s[%0d].hi_digs", tag, i), got_q[i].hi_digs, exp_q[i].hi_digs);
      end
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.in_data  = 8'h00;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      exp_q.delete();
      got_q.delete();
      exp_err = 1'b0;
   endtask

   task automatic wait_out_valid(input string tag);
      int n = 0;
      @(negedge clock);
      bus.in_valid = 1'b0;
      while (bus.out_valid !== 1'b1 && n < 50) begin
         @(negedge clock);
         n++;
      end
      check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd1);
   endtask

   // out_ready changes just after the rising edge so the negedge sampler sees a settled handshake
   initial begin
      bus.out_ready = 1'b0;
      forever begin
         @(posedge clock);
         #2;
         case (rdy_mode)
            0: bus.out_ready = 1'b1;
            1: bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = 1'b0;
         endcase
      end
   end

   initial begin
      rng_t cur, prev_out;
      bit   prev_pend = 1'b0;
      prev_out = '0;
      forever begin
         @(negedge clock);
         cur = {bus.out_lo_m1, bus.out_lo_digs, bus.out_hi, bus.out_hi_digs};
         if (!reset) begin
            if (prev_pend && (bus.out_valid !== 1'b1 || cur !== prev_out)) stable_viol++;
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) got_q.push_back(cur);
         end
         prev_pend = !reset && (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
         prev_out  = cur;
      end
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      bus.in_last  = 1'b0;

      do_reset();
      check("rst_in_ready",  64'(bus.in_ready),  64'd1);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_fmt_err",   64'(fmt_err),       64'd0);
      check("rst_out_lo_m1", 64'(bus.out_lo_m1), 64'd0);
      check("rst_out_hi",    64'(bus.out_hi),    64'd0);
      check("rst_range_cnt", 64'(range_cnt),     64'd0);

      rdy_mode = 0;
      push_str("11-22,", 1'b0);      push_exp(10, 2, 22, 2);
      push_str("95-115,", 1'b0);     push_exp(94, 2, 115, 3);
      push_str("1000-1012\n", 1'b0); push_exp(999, 3, 1012, 4);
      send_stream();
      drain("basic");
      compare_ranges("basic");
      check("basic_fmt_err", 64'(fmt_err), 64'd0);

      push_str("12a-3,7-9,", 1'b0);  push_exp(6, 1, 9, 1);
      send_stream();
      drain("badchar");
      compare_ranges("badchar");
      check("badchar_fmt_err", 64'(fmt_err), 64'd1);

      do_reset();
      rdy_mode = 2;
      push_str("30-20,5-6,", 1'b0);  push_exp(4, 1, 6, 1);
      send_stream();
      wait_out_valid("hold");
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         check($sformatf("hold_in_ready_%0d", i), 64'(bus.in_ready), 64'd0);
      end
      check("hold_fmt_err", 64'(fmt_err), 64'd1);
      rdy_mode = 0;
      drain("hold");
      compare_ranges("hold");
      check("hold_range_cnt", 64'(range_cnt), 64'(EXP_CNT1));

      do_reset();
      push_str("1-5", 1'b1);         push_exp(0, 1, 5, 1);
      send_stream();
      drain("last");
      push_str("2-3,", 1'b0);
      send_stream();
      drain("done");
      check("done_in_ready", 64'(bus.in_ready), 64'd1);
      compare_ranges("last");
      check("last_fmt_err", 64'(fmt_err), 64'd0);

      do_reset();
      rdy_mode = 2;
      push_str("3-4,", 1'b0);
      send_stream();
      wait_out_valid("emit_pending");
      do_reset();
      check("emit_dropped_valid", 64'(bus.out_valid), 64'd0);
      rdy_mode = 0;
      drain("emit_rst");
      compare_ranges("emit_rst");
      check("emit_rst_range_cnt", 64'(range_cnt), 64'd0);

      do_reset();
      rdy_mode = 1;
      gap_en   = 1'b1;
      push_str("\r,,\n9999999999-9999999999,1\r2-3\r4\n12345678901-2,0-5,-5,5-,1-1,100-99,10-10,", 1'b0);
      push_exp(64'd9999999998, 10, 64'd9999999999, 10);
      push_exp(11, 2, 34, 2);
      push_exp(0, 1, 1, 1);
      push_exp(9, 1, 10, 2);
      send_stream();
      drain("bound");
      compare_ranges("bound");
      check("bound_fmt_err", 64'(fmt_err), 64'd1);

      for (int r = 0; r < 3; r++) begin
         do_reset();
         for (int t = 0; t < 40; t++) gen_token(t == 39);
         send_stream();
         drain($sformatf("rand%0d", r));
         check($sformatf("rand%0d_fmt_err", r), 64'(fmt_err), 64'(exp_err));
         compare_ranges($sformatf("rand%0d", r));
      end

      check("send_timeouts", 64'(timeouts), 64'd0);
      check("stable_while_stalled", 64'(stable_viol), 64'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
